// File: rtl/fp_div_pkg.sv
// Shared types and fp32 constants for the FP divider requester.
package fp_div_pkg;

  localparam int FP_W = 32;

  localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F800000;
  localparam logic [FP_W-1:0] FP_NEG_INF = 32'hFF800000;
  localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    HOLD    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  // Quotient for a +-0 divisor: signed infinity, or QNAN when the dividend is also zero.
  function automatic logic [FP_W-1:0] zero_div_result(input logic [FP_W-1:0] a,
                                                      input logic [FP_W-1:0] b);
    if (a[FP_W-2:0] == '0) return FP_QNAN;
    return (a[FP_W-1] ^ b[FP_W-1]) ? FP_NEG_INF : FP_POS_INF;
  endfunction

endpackage

// File: rtl/fp_div_requester_if.sv
// Operand/result handshakes plus the divider wrapper connection for fp_div_requester.
interface fp_div_requester_if;
  import fp_div_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [FP_W-1:0] in_a;
  logic [FP_W-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [FP_W-1:0] out_result;
  logic            out_err;
  logic            div_en;
  logic [FP_W-1:0] div_dataa;
  logic [FP_W-1:0] div_datab;
  logic [FP_W-1:0] div_result;
  logic            div_done;

  modport master (
    input  in_valid, in_a, in_b, out_ready, div_result, div_done,
    output in_ready, out_valid, out_result, out_err, div_en, div_dataa, div_datab
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready, div_result, div_done,
    input  in_ready, out_valid, out_result, out_err, div_en, div_dataa, div_datab
  );

endinterface

// File: rtl/fp_div_watchdog.sv
// Saturating cycle counter with synchronous clear; times both the BUSY watchdog and the RECOVER drain.
module fp_div_watchdog #(
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/fp_div_requester.sv
// Client-side driver for the fixed-latency, reset-less FP divider wrapper, with watchdog and resync.
// Optional build macro: FP_DIV_ZERO_BYPASS_EN (answer +-0 divisors locally without the divider).
module fp_div_requester
  import fp_div_pkg::*;
#(
  parameter int DIV_LATENCY    = 14,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                clock,
  input  logic                reset,
  fp_div_requester_if.master  bus
);

  localparam int              CNT_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DIV_LATENCY - 1);

  state_t          state, state_nxt;
  logic            div_en_q, div_en_nxt;
  logic [FP_W-1:0] dataa_q, dataa_nxt;
  logic [FP_W-1:0] datab_q, datab_nxt;
  logic            ov_q, ov_nxt;
  logic [FP_W-1:0] res_q, res_nxt;
  logic            err_q, err_nxt;
  logic            abort_q, abort_nxt;
  logic            wd_clr, wd_inc;
  logic [CNT_W-1:0] wd_cnt;
`ifdef FP_DIV_ZERO_BYPASS_EN
  logic            byp_q, byp_nxt;
`endif

  fp_div_watchdog #(.CNT_W(CNT_W)) u_wd (
    .clock (clock),
    .reset (reset),
    .clr   (wd_clr),
    .inc   (wd_inc),
    .cnt   (wd_cnt)
  );

  always_comb begin
    state_nxt  = state;
    div_en_nxt = div_en_q;
    dataa_nxt  = dataa_q;
    datab_nxt  = datab_q;
    ov_nxt     = ov_q;
    res_nxt    = res_q;
    err_nxt    = err_q;
    abort_nxt  = abort_q;
    wd_clr     = 1'b0;
    wd_inc     = 1'b0;
`ifdef FP_DIV_ZERO_BYPASS_EN
    byp_nxt    = byp_q;
`endif
    case (state)
      IDLE: begin
        wd_clr = 1'b1;
        if (bus.in_valid) begin
          dataa_nxt = bus.in_a;
          datab_nxt = bus.in_b;
          state_nxt = BUSY;
`ifdef FP_DIV_ZERO_BYPASS_EN
          byp_nxt    = (bus.in_b[FP_W-2:0] == '0);
          div_en_nxt = (bus.in_b[FP_W-2:0] != '0);
`else
          div_en_nxt = 1'b1;
`endif
        end
      end
      BUSY: begin
        wd_inc = 1'b1;
`ifdef FP_DIV_ZERO_BYPASS_EN
        if (byp_q) begin
          byp_nxt   = 1'b0;
          res_nxt   = zero_div_result(dataa_q, datab_q);
          ov_nxt    = 1'b1;
          err_nxt   = 1'b0;
          state_nxt = HOLD;
        end else
`endif
        // Enable must fall on the done edge itself, otherwise the wrapper starts another division.
        if (bus.div_done) begin
          res_nxt    = bus.div_result;
          ov_nxt     = 1'b1;
          err_nxt    = 1'b0;
          div_en_nxt = 1'b0;
          state_nxt  = HOLD;
        end else if (wd_cnt == TO_LAST) begin
          res_nxt    = FP_QNAN;
          ov_nxt     = 1'b1;
          err_nxt    = 1'b1;
          div_en_nxt = 1'b0;
          abort_nxt  = 1'b1;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        wd_clr = 1'b1;
        if (bus.out_ready) begin
          ov_nxt    = 1'b0;
          state_nxt = abort_q ? RECOVER : IDLE;
        end
      end
      RECOVER: begin
        // Keep the enable low long enough for any half-finished wrapper count to run out.
        if (wd_cnt == DRAIN_LAST) begin
          abort_nxt = 1'b0;
          state_nxt = IDLE;
        end else begin
          wd_inc = 1'b1;
        end
      end
      default: state_nxt = RECOVER;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RECOVER;
      div_en_q <= 1'b0;
      dataa_q  <= '0;
      datab_q  <= '0;
      ov_q     <= 1'b0;
      res_q    <= '0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
`ifdef FP_DIV_ZERO_BYPASS_EN
      byp_q    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      div_en_q <= div_en_nxt;
      dataa_q  <= dataa_nxt;
      datab_q  <= datab_nxt;
      ov_q     <= ov_nxt;
      res_q    <= res_nxt;
      err_q    <= err_nxt;
      abort_q  <= abort_nxt;
`ifdef FP_DIV_ZERO_BYPASS_EN
      byp_q    <= byp_nxt;
`endif
    end
  end

  assign bus.in_ready   = (state == IDLE) && !reset;
  assign bus.div_en     = div_en_q;
  assign bus.div_dataa  = dataa_q;
  assign bus.div_datab  = datab_q;
  assign bus.out_valid  = ov_q;
  assign bus.out_result = res_q;
  assign bus.out_err    = err_q;

endmodule
